// File: rtl/seq_alu.sv
// seq_alu: handshaked RV-style ALU; single-cycle ops finish in one cycle,
// shifts iterate one bit per cycle so latency is shamt+1.
module seq_alu #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      control_in,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            branch_taken
);
    localparam int SW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t          state, state_n;
    logic [1:0]      kind;
    logic [SW-1:0]   cnt;
    logic [SW-1:0]   shamt;
    logic            is_shift, lt_s, lt_u, eq, br_take;
    logic [XLEN-1:0] alu_res, shifted;

    assign shamt     = op_b[SW-1:0];
    assign is_shift  = (control_in >= 4'b0101) && (control_in <= 4'b0111);
    assign lt_s      = $signed(op_a) < $signed(op_b);
    assign lt_u      = op_a < op_b;
    assign eq        = op_a == op_b;
    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;

    always_comb begin
        alu_res = '0;
        br_take = 1'b0;
        case (control_in)
            4'b0000: alu_res = op_a + op_b;
            4'b0001: alu_res = op_a - op_b;
            4'b0010: alu_res = op_a ^ op_b;
            4'b0011: alu_res = op_a | op_b;
            4'b0100: alu_res = op_a & op_b;
            4'b1000: alu_res = XLEN'(lt_s);
            4'b1001: alu_res = XLEN'(lt_u);
            4'b1010: br_take = eq;
            4'b1011: br_take = !eq;
            4'b1100: br_take = lt_s;
            4'b1101: br_take = !lt_s;
            4'b1110: br_take = lt_u;
            4'b1111: br_take = !lt_u;
            default: alu_res = '0;
        endcase
        if (control_in >= 4'b1010)
            alu_res = XLEN'(br_take);
    end

    // kind holds control_in[1:0] of the accepted shift: 01 sll, 10 srl, 11 sra
    always_comb begin
        shifted = kind == 2'b01 ? {result[XLEN-2:0], 1'b0} :
                  kind == 2'b10 ? {1'b0, result[XLEN-1:1]} :
                                  {result[XLEN-1], result[XLEN-1:1]};
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (in_valid) state_n = (is_shift && shamt != '0) ? SHIFT : DONE;
            SHIFT:   if (cnt == SW'(1)) state_n = DONE;
            DONE:    if (out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            kind         <= '0;
            cnt          <= '0;
            result       <= '0;
            branch_taken <= 1'b0;
        end else begin
            state <= state_n;
            if (state == IDLE && in_valid) begin
                kind         <= control_in[1:0];
                cnt          <= shamt;
                result       <= is_shift ? op_a : alu_res;
                branch_taken <= br_take;
            end else if (state == SHIFT) begin
                result <= shifted;
                cnt    <= cnt - 1'b1;
            end
        end
    end
endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter XLEN, default 32, giving the operand and result width; the shift amount width is SW = log2(XLEN).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1 bit: the operation request is valid.
REQ-005 SHALL have port in_ready, output, 1 bit: the block can accept a request.
REQ-006 SHALL have port control_in, input, 4 bits: the ALU operation code, as produced by the ALU control decoder.
REQ-007 SHALL have port op_a, input, XLEN bits: the rs1 operand.
REQ-008 SHALL have port op_b, input, XLEN bits: the rs2 operand or immediate.
REQ-009 SHALL have port out_valid, output, 1 bit: result and branch_taken are valid.
REQ-010 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-011 SHALL have port result, output, XLEN bits: the operation result.
REQ-012 SHALL have port branch_taken, output, 1 bit: the branch comparison outcome.

Function
REQ-013 SHALL decode control_in as follows:
- 0000 add, 0001 sub, 0010 xor, 0011 or, 0100 and
- 0101 sll, 0110 srl, 0111 sra
- 1000 slt, 1001 sltu
- 1010 beq, 1011 bne, 1100 blt, 1101 bge, 1110 bltu, 1111 bgeu
REQ-014 SHALL implement a three-state FSM with states IDLE, SHIFT and DONE; in_ready = 1 only in IDLE, and out_valid = 1 only in DONE.
REQ-015 SHALL accept a request when in_valid && in_ready: it captures control_in, op_a, and op_b[SW-1:0] as shamt; input changes after acceptance have no effect.
REQ-016 SHALL, for a non-shift code, compute the result at acceptance and go IDLE->DONE, so out_valid asserts exactly 1 cycle after acceptance.
REQ-017 SHALL, for a shift code with shamt = 0, go IDLE->DONE with result = op_a (latency 1).
REQ-018 SHALL, for a shift code with shamt > 0, go IDLE->SHIFT, load a down-counter with shamt, and shift the working register 1 bit per cycle:
- sll: zero fill
- srl: zero fill
- sra: replicate the sign bit
REQ-019 SHALL go SHIFT->DONE on the cycle the counter reaches 0, so out_valid asserts exactly shamt+1 cycles after acceptance (maximum XLEN cycles).
REQ-020 SHALL perform add and sub modulo 2^XLEN, discarding carry and overflow.
REQ-021 SHALL make slt/sltu produce result = {XLEN-1 zeros, lt}, with a signed comparison for slt and unsigned for sltu.
REQ-022 SHALL, for branch codes, set branch_taken to the comparison outcome and result = {XLEN-1 zeros, branch_taken}, using a signed comparison for blt/bge and unsigned for bltu/bgeu.
REQ-023 SHALL hold branch_taken = 0 for all non-branch codes.
REQ-024 SHALL hold result and branch_taken stable in DONE until out_valid && out_ready, then go DONE->IDLE; a new request cannot be accepted in that same cycle.
REQ-025 SHALL ignore in_valid outside IDLE: no queuing and no error.
REQ-026 SHALL not require any ordering between out_ready and out_valid; out_ready held high gives one result per accept-and-drain cycle.

Reset
REQ-027 SHALL, while rst_n = 0 (async, regardless of clk), force state IDLE, in_ready = 1, out_valid = 0, result = 0, branch_taken = 0, and shift counter = 0.
REQ-028 SHALL, when rst_n asserts mid-SHIFT or in DONE, discard the operation with no result delivered; after release the block is in IDLE ready for a new request on the first rising edge.

Verification
REQ-029 SHALL be verified with: sub, op_a=5, op_b=7, out_ready=1 -> 1 cycle later out_valid=1, result=0xFFFFFFFE, branch_taken=0.
REQ-030 SHALL be verified with: sra, op_a=0x80000000, op_b=31 -> in_ready=0 for 32 cycles, then result=0xFFFFFFFF; repeat with shamt=0 -> result=op_a after 1 cycle.
REQ-031 SHALL be verified with: blt, op_a=0xFFFFFFFF, op_b=1 -> branch_taken=1, result=1; bltu on the same operands -> branch_taken=0, result=0.
REQ-032 SHALL be verified with: out_ready=0 for 5 cycles after out_valid -> result stable and in_ready=0 throughout; one out_ready pulse -> IDLE on the next cycle.
REQ-033 SHALL be verified with: sll, shamt=20, rst_n pulsed low at cycle 6 -> out_valid=0 immediately; after release, add 2+3 -> result=5 with latency 1.
REQ-034 SHALL be verified with: in_valid held high with changing operands during SHIFT -> the in-flight result is unaffected and no extra result is produced.
